// File: rtl/vae_pkg.sv
// rtl/vae_pkg.sv - shared types and Q8.8 reduction helpers; VAE_MAC_SAT_EN selects saturating reduction
package vae_pkg;

  localparam int Q_FRAC = 8;
  localparam int ELEM_W = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_DRAIN = 2'd2,
    ST_OUT   = 2'd3
  } state_e;

  function automatic logic [15:0] sat16(input logic signed [63:0] v);
    if (v > 64'sd32767) begin
      return 16'h7FFF;
    end else if (v < -64'sd32768) begin
      return 16'h8000;
    end
    return v[15:0];
  endfunction

  // Every narrowing to ELEM_W goes through here so both heads and the sum obey one rule.
  function automatic logic [15:0] reduce16(input logic signed [63:0] v);
`ifdef VAE_MAC_SAT_EN
    return sat16(v);
`else
    return v[15:0];
`endif
  endfunction

endpackage

// File: rtl/vae_mac_head.sv
// rtl/vae_mac_head.sv - one head: lane multiplier row, lane adder, bias-seeded accumulator
module vae_mac_head
  import vae_pkg::*;
#(
  parameter int NUM_LANES = 16,
  parameter int ACC_W     = 40
) (
  input  logic                          clk,
  input  logic                          flush_i,
  input  logic                          beat_i,
  input  logic                          first_i,
  input  logic [NUM_LANES*ELEM_W-1:0]   act_i,
  input  logic [NUM_LANES*ELEM_W-1:0]   w_i,
  input  logic [ELEM_W-1:0]             bias_i,
  output logic signed [ACC_W-1:0]       acc_o
);

  localparam int PROD_W = 2 * ELEM_W;

  logic signed [PROD_W-1:0] prod_d [NUM_LANES];
  logic signed [PROD_W-1:0] prod_q [NUM_LANES];
  logic                     s1_valid_q;
  logic                     s1_first_q;
  logic signed [ACC_W-1:0]  lane_sum;
  logic signed [ACC_W-1:0]  bias_ext;
  logic signed [ACC_W-1:0]  acc_d;
  logic signed [ACC_W-1:0]  acc_q;

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    logic signed [ELEM_W-1:0] a;
    logic signed [ELEM_W-1:0] w;
    assign a         = act_i[i*ELEM_W +: ELEM_W];
    assign w         = w_i[i*ELEM_W +: ELEM_W];
    assign prod_d[i] = PROD_W'(a) * PROD_W'(w);
  end

  always_ff @(posedge clk) begin
    if (flush_i) begin
      s1_valid_q <= 1'b0;
      s1_first_q <= 1'b0;
    end else begin
      s1_valid_q <= beat_i;
      s1_first_q <= first_i;
    end
  end

  always_ff @(posedge clk) begin
    if (beat_i) begin
      prod_q <= prod_d;
    end
  end

  always_comb begin
    lane_sum = '0;
    for (int i = 0; i < NUM_LANES; i++) begin
      lane_sum = lane_sum + ACC_W'(prod_q[i]);
    end
  end

  // Bias is Q8.8; shifting by Q_FRAC aligns it with the Q16.16 products.
  assign bias_ext = ACC_W'($signed(bias_i)) <<< Q_FRAC;
  assign acc_d    = s1_first_q ? (bias_ext + lane_sum) : (acc_q + lane_sum);

  always_ff @(posedge clk) begin
    if (flush_i) begin
      acc_q <= '0;
    end else if (s1_valid_q) begin
      acc_q <= acc_d;
    end
  end

  assign acc_o = acc_q;

endmodule

// File: rtl/vae_dual_head_mac.sv
// rtl/vae_dual_head_mac.sv - dual-head (mu/logvar) streaming dot-product engine; VAE_MAC_SAT_EN selects saturation
module vae_dual_head_mac
  import vae_pkg::*;
#(
  parameter int NUM_LANES = 16,
  parameter int BEATS     = 8,
  parameter int ACC_W     = 40
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          clr,
  input  logic [ELEM_W-1:0]             bias_mu,
  input  logic [ELEM_W-1:0]             bias_var,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic                          in_last,
  input  logic [NUM_LANES*ELEM_W-1:0]   in_act,
  input  logic [NUM_LANES*ELEM_W-1:0]   in_w_mu,
  input  logic [NUM_LANES*ELEM_W-1:0]   in_w_var,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [ELEM_W-1:0]             res_mu,
  output logic [ELEM_W-1:0]             res_var,
  output logic [ELEM_W-1:0]             res_sum,
  output logic                          err_len
);

  localparam int              CNT_W    = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BEATS - 1);

  state_e                  state_q, state_d;
  logic [CNT_W-1:0]        beat_cnt_q, beat_cnt_d;
  logic                    err_len_q, err_len_d;
  logic [ELEM_W-1:0]       bias_mu_q, bias_var_q;
  logic                    flush;
  logic                    accept;
  logic                    first_beat;
  logic                    last_beat;
  logic signed [ACC_W-1:0] acc_mu;
  logic signed [ACC_W-1:0] acc_var;

  assign flush      = rst | clr;
  assign accept     = in_valid & in_ready;
  assign first_beat = accept & (state_q == ST_IDLE);
  assign last_beat  = (beat_cnt_q == LAST_CNT);

  always_ff @(posedge clk) begin
    if (flush) begin
      state_q    <= ST_IDLE;
      beat_cnt_q <= '0;
      err_len_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      beat_cnt_q <= beat_cnt_d;
      err_len_q  <= err_len_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE, ST_ACCUM: if (accept) state_d = last_beat ? ST_DRAIN : ST_ACCUM;
      ST_DRAIN:          state_d = ST_OUT;
      ST_OUT:            if (out_ready) state_d = ST_IDLE;
      default:           state_d = ST_IDLE;
    endcase
  end

  // The beat count alone ends a vector; in_last only feeds the sticky length error.
  always_comb begin
    beat_cnt_d = beat_cnt_q;
    err_len_d  = err_len_q;
    if (accept) begin
      beat_cnt_d = last_beat ? '0 : beat_cnt_q + 1'b1;
      if (in_last != last_beat) err_len_d = 1'b1;
    end
  end

  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    if (!rst && !clr && (state_q == ST_IDLE || state_q == ST_ACCUM)) in_ready = 1'b1;
    if (state_q == ST_OUT) out_valid = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bias_mu_q  <= '0;
      bias_var_q <= '0;
    end else if (first_beat) begin
      bias_mu_q  <= bias_mu;
      bias_var_q <= bias_var;
    end
  end

  vae_mac_head #(.NUM_LANES(NUM_LANES), .ACC_W(ACC_W)) u_head_mu (
    .clk     (clk),
    .flush_i (flush),
    .beat_i  (accept),
    .first_i (first_beat),
    .act_i   (in_act),
    .w_i     (in_w_mu),
    .bias_i  (bias_mu_q),
    .acc_o   (acc_mu)
  );

  vae_mac_head #(.NUM_LANES(NUM_LANES), .ACC_W(ACC_W)) u_head_var (
    .clk     (clk),
    .flush_i (flush),
    .beat_i  (accept),
    .first_i (first_beat),
    .act_i   (in_act),
    .w_i     (in_w_var),
    .bias_i  (bias_var_q),
    .acc_o   (acc_var)
  );

  // Accumulators hold still outside of beat processing, so results stay stable through OUT.
  assign res_mu  = reduce16(64'(acc_mu >>> Q_FRAC));
  assign res_var = reduce16(64'(acc_var >>> Q_FRAC));
  assign res_sum = reduce16(64'($signed(res_mu)) + 64'($signed(res_var)));
  assign err_len = err_len_q;

endmodule

// File: tb/tb_vae_dual_head_mac.sv
// tb/tb_vae_dual_head_mac.sv - directed self-checking bench for vae_dual_head_mac
`timescale 1ns/1ps
module tb_vae_dual_head_mac;

  localparam int NL = 16;
  localparam int NB = 8;
  localparam int VW = NL * 16;

`ifdef VAE_MAC_SAT_EN
  localparam logic [15:0] T1_MU = 16'h7FFF;
`else
  localparam logic [15:0] T1_MU = 16'h8000;
`endif

  logic          clk = 1'b0;
  logic          rst, clr;
  logic [15:0]   bias_mu, bias_var;
  logic          in_valid, in_ready, in_last;
  logic [VW-1:0] in_act, in_w_mu, in_w_var;
  logic          out_valid, out_ready;
  logic [15:0]   res_mu, res_var, res_sum;
  logic          err_len;

  int checks = 0;
  int fails  = 0;

  logic [VW-1:0] act_v [NB];
  logic [VW-1:0] wmu_v [NB];
  logic [VW-1:0] wvar_v[NB];
  logic [15:0]   e_mu, e_var, e_sum;

  vae_dual_head_mac dut (
    .clk(clk), .rst(rst), .clr(clr), .bias_mu(bias_mu), .bias_var(bias_var),
    .in_valid(in_valid), .in_ready(in_ready), .in_last(in_last), .in_act(in_act),
    .in_w_mu(in_w_mu), .in_w_var(in_w_var), .out_valid(out_valid), .out_ready(out_ready),
    .res_mu(res_mu), .res_var(res_var), .res_sum(res_sum), .err_len(err_len)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] red(input longint v);
`ifdef VAE_MAC_SAT_EN
    if (v > 32767) return 16'h7FFF;
    if (v < -32768) return 16'h8000;
`endif
    return v[15:0];
  endfunction

  function automatic longint head_model(input bit var_head);
    longint acc;
    logic [15:0] a, w, b;
    b   = var_head ? bias_var : bias_mu;
    acc = longint'($signed(b)) * 256;
    for (int bi = 0; bi < NB; bi++) begin
      for (int l = 0; l < NL; l++) begin
        a = act_v[bi][l*16 +: 16];
        w = var_head ? wvar_v[bi][l*16 +: 16] : wmu_v[bi][l*16 +: 16];
        acc += longint'($signed(a)) * longint'($signed(w));
      end
    end
    return acc >>> 8;
  endfunction

  task automatic compute_expected();
    e_mu  = red(head_model(1'b0));
    e_var = red(head_model(1'b1));
    e_sum = red(longint'($signed(e_mu)) + longint'($signed(e_var)));
  endtask

  task automatic fill_const(input logic [15:0] a, input logic [15:0] wm, input logic [15:0] wv);
    for (int b = 0; b < NB; b++)
      for (int l = 0; l < NL; l++) begin
        act_v[b][l*16 +: 16]  = a;
        wmu_v[b][l*16 +: 16]  = wm;
        wvar_v[b][l*16 +: 16] = wv;
      end
  endtask

  task automatic fill_rand();
    for (int b = 0; b < NB; b++)
      for (int l = 0; l < NL; l++) begin
        act_v[b][l*16 +: 16]  = 16'($urandom_range(0, 65535));
        wmu_v[b][l*16 +: 16]  = 16'($urandom_range(0, 65535));
        wvar_v[b][l*16 +: 16] = 16'($urandom_range(0, 65535));
      end
    bias_mu  = 16'($urandom_range(0, 65535));
    bias_var = 16'($urandom_range(0, 65535));
  endtask

  // Returns at the negedge after the last accepted beat (or after a one-cycle clr abort).
  task automatic drive_vector(input bit gaps, input int last_at, input int clr_at, input int start_b);
    int b = start_b;
    int guard = 0;
    while (b < NB && guard < 500) begin
      @(negedge clk);
      guard++;
      if (gaps && $urandom_range(0, 1) == 0) begin
        in_valid = 1'b0;
        in_last  = 1'b0;
      end else begin
        in_valid = 1'b1;
        in_act   = act_v[b];
        in_w_mu  = wmu_v[b];
        in_w_var = wvar_v[b];
        in_last  = (b == last_at);
        if (b == clr_at) begin
          clr = 1'b1;
          b   = NB;
        end else if (in_ready) begin
          b++;
        end
      end
    end
    checks++;
    if (guard >= 500) begin
      fails++;
      $display("FAIL drive_timeout: beats sent %0d, required %0d", b, NB);
    end
    @(negedge clk);
    in_valid = 1'b0;
    in_last  = 1'b0;
    clr      = 1'b0;
  endtask

  task automatic wait_out();
    int cyc = 0;
    while (!out_valid && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic retire();
    @(negedge clk);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; clr = 1'b0; in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b0;
    in_act = '0; in_w_mu = '0; in_w_var = '0; bias_mu = '0; bias_var = '0;
    repeat (3) @(negedge clk);
    checks++; if (in_ready !== 1'b0) begin fails++; $display("FAIL rst_in_ready: got %b want 0", in_ready); end
    checks++; if (out_valid !== 1'b0) begin fails++; $display("FAIL rst_out_valid: got %b want 0", out_valid); end
    rst = 1'b0;
    #1;
    checks++; if (in_ready !== 1'b1) begin fails++; $display("FAIL rst_release_in_ready: got %b want 1", in_ready); end
    checks++; if ({res_mu, res_var, res_sum} !== 48'h0) begin fails++; $display("FAIL rst_res: got %h %h %h want 0 0 0", res_mu, res_var, res_sum); end
    checks++; if (err_len !== 1'b0) begin fails++; $display("FAIL rst_err_len: got %b want 0", err_len); end
  endtask

  task automatic test_overflow_point();
    bias_mu = 16'h0000; bias_var = 16'h0000;
    fill_const(16'h0100, 16'h0100, 16'h0000);
    drive_vector(1'b0, NB-1, -1, 0);
    checks++; if (out_valid !== 1'b0) begin fails++; $display("FAIL t1_latency_early: out_valid %b want 0", out_valid); end
    @(negedge clk);
    checks++; if (out_valid !== 1'b1) begin fails++; $display("FAIL t1_latency: out_valid %b want 1", out_valid); end
    checks++; if (res_mu !== T1_MU) begin fails++; $display("FAIL t1_res_mu: got %h want %h", res_mu, T1_MU); end
    checks++; if (res_var !== 16'h0000) begin fails++; $display("FAIL t1_res_var: got %h want 0000", res_var); end
    checks++; if (res_sum !== T1_MU) begin fails++; $display("FAIL t1_res_sum: got %h want %h", res_sum, T1_MU); end
    checks++; if (err_len !== 1'b0) begin fails++; $display("FAIL t1_err_len: got %b want 0", err_len); end
    retire();
    checks++; if (out_valid !== 1'b0) begin fails++; $display("FAIL t1_retire: out_valid %b want 0", out_valid); end
  endtask

  task automatic test_q88_bias();
    bias_mu = 16'hFC9C; bias_var = 16'hFFF2;
    fill_const(16'h0080, 16'h0002, 16'hFFFE);
    drive_vector(1'b0, NB-1, -1, 0);
    wait_out();
    checks++; if (res_mu !== 16'hFD1C) begin fails++; $display("FAIL t2_res_mu: got %h want FD1C", res_mu); end
    checks++; if (res_var !== 16'hFF72) begin fails++; $display("FAIL t2_res_var: got %h want FF72", res_var); end
    checks++; if (res_sum !== 16'hFC8E) begin fails++; $display("FAIL t2_res_sum: got %h want FC8E", res_sum); end
    retire();
  endtask

  task automatic test_random_stall_back_to_back();
    fill_rand();
    compute_expected();
    drive_vector(1'b1, NB-1, -1, 0);
    wait_out();
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      checks++;
      if ({out_valid, res_mu, res_var, res_sum} !== {1'b1, e_mu, e_var, e_sum}) begin
        fails++;
        $display("FAIL t3_stall_c%0d: got v=%b %h %h %h want v=1 %h %h %h", c, out_valid, res_mu, res_var, res_sum, e_mu, e_var, e_sum);
      end
    end
    fill_rand();
    compute_expected();
    out_ready = 1'b1;
    in_valid = 1'b1; in_last = 1'b0;
    in_act = act_v[0]; in_w_mu = wmu_v[0]; in_w_var = wvar_v[0];
    checks++; if (in_ready !== 1'b0) begin fails++; $display("FAIL b2b_ready_in_out: got %b want 0", in_ready); end
    @(negedge clk);
    out_ready = 1'b0;
    checks++; if (out_valid !== 1'b0) begin fails++; $display("FAIL b2b_retired: out_valid %b want 0", out_valid); end
    checks++; if (in_ready !== 1'b1) begin fails++; $display("FAIL b2b_ready_next: got %b want 1", in_ready); end
    drive_vector(1'b0, NB-1, -1, 1);
    wait_out();
    checks++;
    if ({out_valid, res_mu, res_var, res_sum} !== {1'b1, e_mu, e_var, e_sum}) begin
      fails++;
      $display("FAIL b2b_result: got v=%b %h %h %h want v=1 %h %h %h", out_valid, res_mu, res_var, res_sum, e_mu, e_var, e_sum);
    end
    retire();
  endtask

  task automatic test_clr_abort();
    fill_rand();
    drive_vector(1'b0, NB-1, 4, 0);
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      checks++; if (out_valid !== 1'b0) begin fails++; $display("FAIL t4_no_out_c%0d: out_valid %b want 0", c, out_valid); end
    end
    fill_rand();
    compute_expected();
    drive_vector(1'b0, NB-1, -1, 0);
    wait_out();
    checks++;
    if ({out_valid, res_mu, res_var, res_sum} !== {1'b1, e_mu, e_var, e_sum}) begin
      fails++;
      $display("FAIL t4_second_vector: got v=%b %h %h %h want v=1 %h %h %h", out_valid, res_mu, res_var, res_sum, e_mu, e_var, e_sum);
    end
    retire();
    repeat (3) @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin fails++; $display("FAIL t4_extra_out: out_valid %b want 0", out_valid); end
  endtask

  task automatic test_err_len();
    fill_rand();
    compute_expected();
    drive_vector(1'b0, 5, -1, 0);
    wait_out();
    checks++; if (err_len !== 1'b1) begin fails++; $display("FAIL t5_err_set: got %b want 1", err_len); end
    checks++;
    if ({out_valid, res_mu, res_var, res_sum} !== {1'b1, e_mu, e_var, e_sum}) begin
      fails++;
      $display("FAIL t5_result: got v=%b %h %h %h want v=1 %h %h %h", out_valid, res_mu, res_var, res_sum, e_mu, e_var, e_sum);
    end
    retire();
    checks++; if (err_len !== 1'b1) begin fails++; $display("FAIL t5_err_sticky: got %b want 1", err_len); end
    @(negedge clk); clr = 1'b1;
    @(negedge clk); clr = 1'b0;
    checks++; if (err_len !== 1'b0) begin fails++; $display("FAIL t5_err_clr: got %b want 0", err_len); end
  endtask

  task automatic test_rst_in_out();
    bias_mu = 16'hFC9C; bias_var = 16'hFFF2;
    fill_const(16'h0080, 16'h0002, 16'hFFFE);
    drive_vector(1'b0, NB-1, -1, 0);
    wait_out();
    checks++; if (out_valid !== 1'b1) begin fails++; $display("FAIL t6_out: out_valid %b want 1", out_valid); end
    rst = 1'b1;
    @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin fails++; $display("FAIL t6_out_valid: got %b want 0", out_valid); end
    checks++; if ({res_mu, res_var, res_sum} !== 48'h0) begin fails++; $display("FAIL t6_res: got %h %h %h want 0 0 0", res_mu, res_var, res_sum); end
    checks++; if (in_ready !== 1'b0) begin fails++; $display("FAIL t6_ready_in_rst: got %b want 0", in_ready); end
    rst = 1'b0;
    #1;
    checks++; if (in_ready !== 1'b1) begin fails++; $display("FAIL t6_ready_after: got %b want 1", in_ready); end
  endtask

  initial begin
    test_reset();
    test_overflow_point();
    test_q88_bias();
    test_random_stall_back_to_back();
    test_clr_abort();
    test_err_len();
    test_rst_in_out();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
